// File: rtl/vga_pkg.sv
// vga_pkg: shared types and helpers for the VGA timing generator.
package vga_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        WAIT_FILL = 1'b0,
        RUN       = 1'b1
    } state_t;

    // Total line length in pixels, or frame length in lines.
    function automatic int calc_total(input int disp, input int fp, input int pulse, input int bp);
        return disp + fp + pulse + bp;
    endfunction

endpackage

// File: rtl/vga_counter.sv
// vga_counter: up-counter 0..MAX-1 that advances when en is high and wraps to 0.
// wrap is high in the cycle where an enabled count leaves MAX-1.
module vga_counter
    import vga_pkg::*;
#(
    parameter int MAX = 928,
    parameter int W   = $clog2(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == W'(MAX - 1));

    // count register, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/blank generation fed from a pixel FIFO.
// Optional build macro VGA_TESTPATTERN_EN replaces FIFO data with an
// internal grid pattern, never reads the FIFO and starts running out of reset.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_FILL | counters parked at 0, outputs idle, waiting for almost-full
// RUN       | counters free-running, one FIFO read per active pixel
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_rempty,
    input  logic        fifo_walmost_full,
    output logic        fifo_read,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK,
    output logic [23:0] VGA_RGB,
    output logic        underflow
);

    localparam int HTOTAL = calc_total(HDISP, HFP, HPULSE, HBP);
    localparam int VTOTAL = calc_total(VDISP, VFP, VPULSE, VBP);
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    localparam logic [HW-1:0] H_ACT_END = HW'(HDISP);
    localparam logic [HW-1:0] HS_START  = HW'(HDISP + HFP);
    localparam logic [HW-1:0] HS_END    = HW'(HDISP + HFP + HPULSE);
    localparam logic [VW-1:0] V_ACT_END = VW'(VDISP);
    localparam logic [VW-1:0] VS_START  = VW'(VDISP + VFP);
    localparam logic [VW-1:0] VS_END    = VW'(VDISP + VFP + VPULSE);

    state_t        state;
    state_t        state_nx;
    logic          run;
    logic          active;
    logic          hs_win;
    logic          vs_win;
    logic          hwrap;
    logic          vwrap_unused;
    logic          underflow_set;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    assign run = (state == RUN);

    vga_counter #(.MAX(HTOTAL)) u_hcnt (
        .clk  (pixel_clk),
        .rst  (pixel_rst),
        .en   (run),
        .cnt  (hcnt),
        .wrap (hwrap)
    );

    vga_counter #(.MAX(VTOTAL)) u_vcnt (
        .clk  (pixel_clk),
        .rst  (pixel_rst),
        .en   (hwrap),
        .cnt  (vcnt),
        .wrap (vwrap_unused)
    );

    assign active = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
    assign hs_win = (hcnt >= HS_START) && (hcnt < HS_END);
    assign vs_win = (vcnt >= VS_START) && (vcnt < VS_END);

    // state register
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state <= WAIT_FILL;
        end else begin
            state <= state_nx;
        end
    end

    // next state, FIFO read strobe and underflow detection
    always_comb begin
        state_nx      = state;
        fifo_read     = 1'b0;
        underflow_set = 1'b0;
`ifdef VGA_TESTPATTERN_EN
        state_nx = RUN;
`else
        if (state == WAIT_FILL && fifo_walmost_full) begin
            state_nx = RUN;
        end
        if (state == RUN && active) begin
            // An empty FIFO costs the pixel; no catch-up read is issued later.
            fifo_read     = !fifo_rempty;
            underflow_set = fifo_rempty;
        end
`endif
    end

    // sync/blank registered one cycle behind the counters; sticky underflow
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b0;
            underflow <= 1'b0;
        end else begin
            VGA_HS    <= !(run && hs_win);
            VGA_VS    <= !(run && vs_win);
            VGA_BLANK <= run && active;
            if (underflow_set) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef VGA_TESTPATTERN_EN
    logic [23:0] pat_q;

    // grid pattern: white on every 16th column and row
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            pat_q <= '0;
        end else begin
            pat_q <= (run && active && (hcnt[3:0] == 4'd0 || vcnt[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
        end
    end

    assign VGA_RGB = VGA_BLANK ? pat_q : 24'h000000;
`else
    logic pix_ok_q;
    rgb_t pix;

    // remember whether the displayed pixel actually got a FIFO read
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            pix_ok_q <= 1'b0;
        end else begin
            pix_ok_q <= fifo_read;
        end
    end

    // FIFO data arrives the cycle after the read, aligned with registered BLANK
    assign pix     = rgb_t'(fifo_rdata);
    assign VGA_RGB = (VGA_BLANK && pix_ok_q) ? {pix.r, pix.g, pix.b} : 24'h000000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen. The vertical timing is
// shortened in the default build so several frames fit in a short run.
module tb_vga_timing_gen;

`ifdef VGA_TESTPATTERN_EN
    localparam int P_HDISP = 160, P_VDISP = 90, P_VFP = 13, P_VPULSE = 3, P_VBP = 29;
`else
    localparam int P_HDISP = 800, P_VDISP = 8, P_VFP = 2, P_VPULSE = 3, P_VBP = 2;
`endif
    localparam int P_HFP = 40, P_HPULSE = 48, P_HBP = 40;
    localparam int HT    = P_HDISP + P_HFP + P_HPULSE + P_HBP;
    localparam int VT    = P_VDISP + P_VFP + P_VPULSE + P_VBP;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] fifo_rdata = '0;
    logic        fifo_rempty;
    logic        af;
    logic        fifo_read;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK;
    logic [23:0] VGA_RGB;
    logic        underflow;

    int vectors     = 0;
    int miscompares = 0;
    int pop_cnt     = 0;
    int kpos        = 0;

    vga_timing_gen #(
        .HDISP(P_HDISP), .VDISP(P_VDISP), .HFP(P_HFP), .HPULSE(P_HPULSE),
        .HBP(P_HBP), .VFP(P_VFP), .VPULSE(P_VPULSE), .VBP(P_VBP)
    ) dut (
        .pixel_clk         (clk),
        .pixel_rst         (rst),
        .fifo_rdata        (fifo_rdata),
        .fifo_rempty       (fifo_rempty),
        .fifo_walmost_full (af),
        .fifo_read         (fifo_read),
        .VGA_HS            (VGA_HS),
        .VGA_VS            (VGA_VS),
        .VGA_BLANK         (VGA_BLANK),
        .VGA_RGB           (VGA_RGB),
        .underflow         (underflow)
    );

    always #5 clk = ~clk;

    // FIFO model: each read returns the next value of an incrementing sequence
    always @(posedge clk) begin
        if (fifo_read === 1'b1) begin
            fifo_rdata <= 24'(pop_cnt);
            pop_cnt    <= pop_cnt + 1;
        end
    end

    function automatic logic exp_active(input int p);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        return (h < P_HDISP) && (v < P_VDISP);
    endfunction

    function automatic logic exp_hs(input int p);
        int h;
        h = p % HT;
        return !((h >= P_HDISP + P_HFP) && (h < P_HDISP + P_HFP + P_HPULSE));
    endfunction

    function automatic logic exp_vs(input int p);
        int v;
        v = (p / HT) % VT;
        return !((v >= P_VDISP + P_VFP) && (v < P_VDISP + P_VFP + P_VPULSE));
    endfunction

    // advance one clock; kpos counts cycles since RUN entry
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        kpos++;
    endtask

    // one-cycle almost-full pulse; kpos=0 right after the edge that samples it
    task automatic pulse_af();
        af = 1'b1;
        @(posedge clk);
        @(negedge clk);
        af   = 1'b0;
        kpos = 0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; af = 1'b0; fifo_rempty = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (fifo_read !== 1'b0) begin miscompares++; $display("FAIL reset_read: got %b expected 0", fifo_read); end
        vectors++; if (VGA_HS !== 1'b1) begin miscompares++; $display("FAIL reset_hs: got %b expected 1", VGA_HS); end
        vectors++; if (VGA_VS !== 1'b1) begin miscompares++; $display("FAIL reset_vs: got %b expected 1", VGA_VS); end
        vectors++; if (VGA_BLANK !== 1'b0) begin miscompares++; $display("FAIL reset_blank: got %b expected 0", VGA_BLANK); end
        vectors++; if (VGA_RGB !== 24'h0) begin miscompares++; $display("FAIL reset_rgb: got %h expected 000000", VGA_RGB); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
        rst = 1'b0;
`ifndef VGA_TESTPATTERN_EN
        bad = 0;
        for (int n = 0; n < 2000; n++) begin
            if (fifo_read !== 1'b0 || VGA_HS !== 1'b1 || VGA_VS !== 1'b1 || VGA_BLANK !== 1'b0) bad++;
            step();
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL wait_fill_idle: got %0d non-idle cycles expected 0", bad); end
`endif
    endtask

`ifndef VGA_TESTPATTERN_EN
    task automatic test_timing();
        int first_fall, second_fall, hs_low, vs_first, vs_low, reads;
        int bad_sync, bad_rgb, bad_rd, bad_uf, exp_val, p;
        logic prev_hs, prev_vs, eb;
        logic [23:0] ergb;
        first_fall = -1; second_fall = -1; vs_first = -1;
        hs_low = 0; vs_low = 0; reads = 0;
        bad_sync = 0; bad_rgb = 0; bad_rd = 0; bad_uf = 0;
        exp_val = pop_cnt;
        fifo_rempty = 1'b0;
        pulse_af();
        prev_hs = 1'b1; prev_vs = 1'b1;
        for (int n = 0; n < FRAME + HT; n++) begin
            if (fifo_read !== exp_active(kpos)) bad_rd++;
            if (kpos < FRAME && fifo_read === 1'b1) reads++;
            if (kpos >= 1) begin
                p  = kpos - 1;
                eb = exp_active(p);
                ergb = eb ? 24'(exp_val) : 24'h0;
                if (eb) exp_val++;
                if (VGA_BLANK !== eb || VGA_HS !== exp_hs(p) || VGA_VS !== exp_vs(p)) bad_sync++;
                if (VGA_RGB !== ergb) bad_rgb++;
            end
            if (prev_hs === 1'b1 && VGA_HS === 1'b0) begin
                if (first_fall < 0) first_fall = kpos;
                else if (second_fall < 0) second_fall = kpos;
            end
            if (kpos >= 1 && kpos <= HT && VGA_HS === 1'b0) hs_low++;
            if (prev_vs === 1'b1 && VGA_VS === 1'b0 && vs_first < 0) vs_first = kpos;
            if (kpos >= 1 && kpos <= FRAME && VGA_VS === 1'b0) vs_low++;
            if (underflow !== 1'b0) bad_uf++;
            prev_hs = VGA_HS; prev_vs = VGA_VS;
            step();
        end
        vectors++; if (first_fall != 841) begin miscompares++; $display("FAIL hs_first_fall: got %0d expected 841", first_fall); end
        vectors++; if (second_fall - first_fall != 928) begin miscompares++; $display("FAIL hs_period: got %0d expected 928", second_fall - first_fall); end
        vectors++; if (hs_low != 48) begin miscompares++; $display("FAIL hs_width: got %0d expected 48", hs_low); end
        vectors++; if (vs_first != 10 * 928 + 1) begin miscompares++; $display("FAIL vs_first_fall: got %0d expected %0d", vs_first, 10 * 928 + 1); end
        vectors++; if (vs_low != 3 * 928) begin miscompares++; $display("FAIL vs_width: got %0d expected %0d", vs_low, 3 * 928); end
        vectors++; if (reads != 800 * 8) begin miscompares++; $display("FAIL reads_per_frame: got %0d expected %0d", reads, 800 * 8); end
        vectors++; if (bad_sync != 0) begin miscompares++; $display("FAIL sync_blank_model: got %0d bad cycles expected 0", bad_sync); end
        vectors++; if (bad_rgb != 0) begin miscompares++; $display("FAIL rgb_data: got %0d bad cycles expected 0", bad_rgb); end
        vectors++; if (bad_rd != 0) begin miscompares++; $display("FAIL read_strobe: got %0d bad cycles expected 0", bad_rd); end
        vectors++; if (bad_uf != 0) begin miscompares++; $display("FAIL no_underflow: got %0d flagged cycles expected 0", bad_uf); end
    endtask

    task automatic test_underflow();
        int target, next_val;
        target = (kpos / FRAME) * FRAME + 5 * HT + 100;
        if (target <= kpos) target += FRAME;
        while (kpos < target) step();
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL uf_before: got %b expected 0", underflow); end
        fifo_rempty = 1'b1;
        #1;
        vectors++; if (fifo_read !== 1'b0) begin miscompares++; $display("FAIL uf_no_read: got %b expected 0", fifo_read); end
        step();
        fifo_rempty = 1'b0;
        #1;
        vectors++; if (VGA_BLANK !== 1'b1) begin miscompares++; $display("FAIL uf_blank: got %b expected 1", VGA_BLANK); end
        vectors++; if (VGA_RGB !== 24'h0) begin miscompares++; $display("FAIL uf_pixel_black: got %h expected 000000", VGA_RGB); end
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL uf_set: got %b expected 1", underflow); end
        vectors++; if (fifo_read !== 1'b1) begin miscompares++; $display("FAIL uf_read_resumes: got %b expected 1", fifo_read); end
        next_val = pop_cnt;
        step();
        vectors++; if (VGA_RGB !== 24'(next_val)) begin miscompares++; $display("FAIL uf_next_pixel: got %h expected %h", VGA_RGB, 24'(next_val)); end
        for (int n = 0; n < FRAME; n++) step();
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL uf_sticky: got %b expected 1", underflow); end
    endtask

    task automatic test_reset_midline();
        int target, bad, base, fall;
        target = (kpos / FRAME) * FRAME + 6 * HT + 400;
        if (target <= kpos) target += FRAME;
        while (kpos < target) step();
        vectors++; if (VGA_BLANK !== 1'b1) begin miscompares++; $display("FAIL mid_active_before: got %b expected 1", VGA_BLANK); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (fifo_read !== 1'b0) begin miscompares++; $display("FAIL mid_rst_read: got %b expected 0", fifo_read); end
        vectors++; if (VGA_HS !== 1'b1) begin miscompares++; $display("FAIL mid_rst_hs: got %b expected 1", VGA_HS); end
        vectors++; if (VGA_VS !== 1'b1) begin miscompares++; $display("FAIL mid_rst_vs: got %b expected 1", VGA_VS); end
        vectors++; if (VGA_BLANK !== 1'b0) begin miscompares++; $display("FAIL mid_rst_blank: got %b expected 0", VGA_BLANK); end
        vectors++; if (VGA_RGB !== 24'h0) begin miscompares++; $display("FAIL mid_rst_rgb: got %h expected 000000", VGA_RGB); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL mid_rst_underflow: got %b expected 0", underflow); end
        repeat (3) @(negedge clk);
        rst = 1'b0; af = 1'b0; fifo_rempty = 1'b0;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            if (fifo_read !== 1'b0 || VGA_BLANK !== 1'b0 || VGA_HS !== 1'b1 || VGA_VS !== 1'b1) bad++;
            step();
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL mid_rewait_idle: got %0d non-idle cycles expected 0", bad); end
        base = pop_cnt;
        pulse_af();
        step();
        vectors++; if (VGA_BLANK !== 1'b1) begin miscompares++; $display("FAIL restart_blank: got %b expected 1", VGA_BLANK); end
        vectors++; if (VGA_RGB !== 24'(base)) begin miscompares++; $display("FAIL restart_rgb: got %h expected %h", VGA_RGB, 24'(base)); end
        fall = -1;
        for (int n = 0; n < 2000 && fall < 0; n++) begin
            step();
            if (VGA_HS === 1'b0) fall = kpos;
        end
        vectors++; if (fall != 841) begin miscompares++; $display("FAIL restart_hs_fall: got %0d expected 841", fall); end
    endtask
`else
    task automatic test_testpattern();
        int p1, p2, p3, reads;
        p1 = 3 * HT + 16;
        p2 = 3 * HT + 17;
        p3 = 32 * HT + 5;
        reads = 0;
        rst = 1'b1; af = 1'b0; fifo_rempty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        kpos = 0;
        for (int n = 0; n <= p3 + 2; n++) begin
            if (fifo_read !== 1'b0) reads++;
            if (kpos == p1 + 1) begin
                vectors++; if (VGA_RGB !== 24'hFFFFFF) begin miscompares++; $display("FAIL tp_16_3: got %h expected ffffff", VGA_RGB); end
                vectors++; if (VGA_BLANK !== 1'b1) begin miscompares++; $display("FAIL tp_16_3_blank: got %b expected 1", VGA_BLANK); end
            end
            if (kpos == p2 + 1) begin
                vectors++; if (VGA_RGB !== 24'h000000) begin miscompares++; $display("FAIL tp_17_3: got %h expected 000000", VGA_RGB); end
            end
            if (kpos == p3 + 1) begin
                vectors++; if (VGA_RGB !== 24'hFFFFFF) begin miscompares++; $display("FAIL tp_5_32: got %h expected ffffff", VGA_RGB); end
            end
            step();
        end
        vectors++; if (reads != 0) begin miscompares++; $display("FAIL tp_no_reads: got %0d read cycles expected 0", reads); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL tp_no_underflow: got %b expected 0", underflow); end
    endtask
`endif

    initial begin
        rst = 1'b1; af = 1'b0; fifo_rempty = 1'b0;
        test_reset();
`ifdef VGA_TESTPATTERN_EN
        test_testpattern();
`else
        test_timing();
        test_underflow();
        test_reset_midline();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Display-side stage between the pixel FIFO read port and the video_if output that the screen model samples.
- Generates horizontal and vertical video timing, pulls one pixel from the FIFO per active pixel, and drives sync, blank and RGB outputs.
- Holds the display blanked until the FIFO first reports almost-full. After that it runs free and flags underflows.

Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP, 40, horizontal front porch (pixels)
- HPULSE, 48, horizontal sync width (pixels)
- HBP, 40, horizontal back porch (pixels)
- VFP, 13, vertical front porch (lines)
- VPULSE, 3, vertical sync width (lines)
- VBP, 29, vertical back porch (lines)

Ports:
- pixel_clk  in  1  pixel clock; sole clock
- pixel_rst  in  1  asynchronous, active-high reset
- fifo_rdata  in  24  pixel from FIFO, {R,G,B}; valid the cycle after fifo_read
- fifo_rempty  in  1  FIFO empty
- fifo_walmost_full  in  1  FIFO almost full, already synchronised to pixel_clk
- fifo_read  out  1  FIFO read strobe
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK  out  1  1 during active area, 0 during blanking
- VGA_RGB  out  24  pixel data
- underflow  out  1  sticky error flag

Behaviour:
- Totals: HTOTAL = HDISP+HFP+HPULSE+HBP (928); VTOTAL = VDISP+VFP+VPULSE+VBP (525). Counter widths are $clog2 of each total.
- Counters:
  - hcnt runs 0..HTOTAL-1 and wraps to 0.
  - vcnt increments when hcnt wraps, and wraps to 0 after VTOTAL-1.
- Active area: hcnt<HDISP && vcnt<VDISP.
- Sync windows:
  - HS low while HDISP+HFP <= hcnt < HDISP+HFP+HPULSE.
  - VS low while VDISP+VFP <= vcnt < VDISP+VFP+VPULSE.
- FSM has two states:
  - WAIT_FILL: counters are held at 0, fifo_read=0, all outputs at idle. Transition to RUN on the first cycle with fifo_walmost_full=1.
  - RUN: counters advance every cycle. No return to WAIT_FILL except by reset.
- fifo_read is combinational: (state==RUN) && active && !fifo_rempty.
- Latency:
  - VGA_HS, VGA_VS and VGA_BLANK are registered from the counters, so they lag the counters by 1 cycle.
  - VGA_RGB takes fifo_rdata in that same registered cycle, so all outputs stay aligned.
  - VGA_RGB is forced to 0 when the registered BLANK is 0.
- Underflow:
  - In RUN, an active pixel with fifo_rempty=1 sets underflow. The flag stays set until reset.
  - That pixel is output as 0. No read is issued and no catch-up is attempted; the image shifts.
- Reset values (also asserted mid-frame on pixel_rst): state=WAIT_FILL, hcnt=vcnt=0, VGA_HS=1, VGA_VS=1, VGA_BLANK=0, VGA_RGB=0, underflow=0. fifo_read=0 throughout reset.
- Simultaneous events:
  - Almost-full and empty cannot both be set.
  - The almost-full→RUN transition takes effect on the next cycle, with hcnt=0 at that point.

Optional Feature:
- Macro: VGA_TESTPATTERN_EN
- Defined:
  - VGA_RGB carries an internal pattern: 24'hFFFFFF when hcnt[3:0]==0 or vcnt[3:0]==0, else 24'h000000 (registered, same latency).
  - fifo_read is held at 0 and underflow is never set.
  - WAIT_FILL is skipped; reset exits directly to RUN.
- Undefined: behaviour exactly as above.

Decomposition:
- Package vga_pkg holds:
  - typedef rgb_t (struct with r, g, b fields, 8 bits each)
  - localparam function computing HTOTAL and VTOTAL
  - FSM enum state_t {WAIT_FILL, RUN}
- One sub-module, vga_counter: a parametric wrap counter (MAX, enable, wrap output), instantiated for h and v.

Test Plan:
- Reset, almost_full=0 for 2000 cycles -> fifo_read=0, HS=VS=1, BLANK=0 throughout.
- Pulse almost_full; FIFO model never empty -> HS low period 928 cycles, width 48, first falling edge 1+840 cycles after RUN entry. VS period 928*525, width 3*928. Exactly 800*480 reads per frame.
- FIFO model returns incrementing data -> RGB at each BLANK=1 cycle equals the value read the previous cycle. RGB=0 whenever BLANK=0.
- Force fifo_rempty=1 for one active pixel in line 5 -> no read that cycle, RGB=0 for that pixel, underflow=1 and still 1 a frame later.
- Assert pixel_rst mid-line 200 -> outputs at reset values immediately (asynchronous). After release, block waits for almost_full again.
- Build with VGA_TESTPATTERN_EN and HDISP=160, VDISP=90 -> fifo_read never 1. Pixel (16,3) is white, (17,3) is black, (5,32) is white.
